wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter between the EX/WB pipeline register outputs and the ROB result write ports. It accepts completed results from NUM_SRC execution sources (ALU, forwarder, jump, branch, mem) into one-entry hold buffers. Each cycle it grants up to NUM_PORTS buffered results, round-robin, onto registered ROB write ports. A flush input discards all in-flight results on misprediction recovery.

## Interface
- NUM_SRC, 5, number of result sources; source index order is ALU=0, forwarder=1, jump=2, branch=3, mem=4.
- NUM_PORTS, 2, number of ROB write ports (1..NUM_SRC).
- TAG_W, 6, ROB tag width; equals the common_def.h tag width.
- PAY_W, 65, payload width per source (widest source record; narrower sources zero-extend).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all buffered and outgoing results.
- src_tag  in  NUM_SRC*TAG_W  per-source target tag; TAG_INVALID (common_def.h) means no result.
- src_pay  in  NUM_SRC*PAY_W  per-source payload.
- src_ready  out  NUM_SRC  source may present a new result this cycle.
- wb_tag  out  NUM_PORTS*TAG_W  registered ROB write tag; TAG_INVALID when idle.
- wb_pay  out  NUM_PORTS*PAY_W  registered payload.
- wb_src  out  NUM_PORTS*3  index of the source granted on each port.
- occ_cnt  out  3  number of occupied hold buffers (registered).

## Operation
- Per-source hold buffer: valid bit, tag, payload.
- A transfer from source i occurs when src_tag[i] != TAG_INVALID and src_ready[i]=1. The buffer captures the result at that edge.
- A valid tag presented while src_ready[i]=0 is ignored. The source must hold the result until it sees ready.
- src_ready[i] = !flush && (!buf_v[i] || grant[i]). This is combinational. A granted buffer refills in the same edge.
- Arbitration is combinational over buf_v:
  - Scan indices rr_ptr, rr_ptr+1, … mod NUM_SRC.
  - The first NUM_PORTS occupied buffers are granted to ports 0..NUM_PORTS-1, in scan order.
- Output registers, for each port p: if granted, wb_tag/pay/src load from the granted buffer. Otherwise wb_tag ← TAG_INVALID. wb_pay and wb_src are don't-care when the tag is invalid.
- A granted buffer clears unless the same source refills it in that edge.
- rr_ptr ← (index of last granted source + 1) mod NUM_SRC. It is unchanged when nothing is granted.
- Fairness: an occupied buffer is granted within ceil(NUM_SRC/NUM_PORTS) cycles.
- occ_cnt ← popcount of next-state buf_v.
- flush=1:
  - All buf_v are cleared at the edge.
  - All wb_tag ← TAG_INVALID.
  - rr_ptr ← 0 and occ_cnt ← 0.
  - src_ready=0 for the flush cycle; results presented that cycle are dropped.
- Reset (rst_n low, asynchronous):
  - buf_v=0, rr_ptr=0, occ_cnt=0.
  - All wb_tag=TAG_INVALID; wb_pay=0; wb_src=0.
  - src_ready evaluates to 1 once flush is low.
  - Reset mid-operation discards all results without any write to the ROB.

## Timing
- Latency: a result accepted at edge E appears on wb_tag at edge E+1 at the earliest, when it is granted in the cycle following E.
- Throughput:
  - Up to NUM_PORTS results per cycle out.
  - One result per source per cycle in, sustained whenever that source is granted every cycle.
- Simultaneous grant and refill of the same buffer are legal. The old entry goes out and the new entry is stored.
- Flush has priority over grant and accept in the same cycle.
- A tag is never written on two ports or in two cycles.

## Test plan
- Reset, then all five sources present tags 1..5 at one edge:
  - First output cycle: ports 0/1 carry tags 1, 2.
  - Second output cycle: tags 3, 4.
  - Third output cycle: tag 5 on port 0 and TAG_INVALID on port 1.
  - src_ready[0,1] returns high in the cycle of their grant.
- Round-robin rotation: rr_ptr=3 and buffers 0,1,4 full → grants are 4 (port 0) and 0 (port 1), then rr_ptr=1.
- Sustained back-pressure: source 2 presents a new tag every cycle while all buffers stay full → source 2 is granted at least every 3rd cycle and no tag is lost or duplicated.
- Flush with occ_cnt=4 → the next cycle has all wb_tag=TAG_INVALID and occ_cnt=0. A tag presented during the flush cycle never appears.
- rst_n asserted low mid-stream with 3 buffers full → outputs go to TAG_INVALID immediately, without waiting for a clock edge. After release, the first new tag 7 on source 4 appears on port 0 one cycle after acceptance.
- Same-edge grant and refill: buffer 1 holds tag 9 and is granted while source 1 presents tag 10 → tag 9 goes out this cycle and tag 10 goes out in the next cycle, in order, with no drop.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: collects completed results from the execution sources into
// one-entry hold buffers and drains them, round-robin, onto registered ROB
// result write ports. A flush empties every buffer and idles the ports.
//
// Source handshake: a result moves from source i into its hold buffer on a
// rising edge where src_tag[i] != TAG_INVALID and src_ready[i] == 1. A source
// that sees src_ready[i] == 0 keeps its result on src_tag/src_pay unchanged
// until it sees ready. src_ready[i] is combinational and may rise in the same
// cycle the buffer is granted, so one source can stream a result per cycle.
module wb_arbiter #(
    parameter int               NUM_SRC     = 5,
    parameter int               NUM_PORTS   = 2,
    parameter int               TAG_W       = 6,
    parameter int               PAY_W       = 65,
    parameter logic [TAG_W-1:0] TAG_INVALID = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
    input  logic [NUM_SRC*PAY_W-1:0]   src_pay,
    output logic [NUM_SRC-1:0]         src_ready,
    output logic [NUM_PORTS*TAG_W-1:0] wb_tag,
    output logic [NUM_PORTS*PAY_W-1:0] wb_pay,
    output logic [NUM_PORTS*3-1:0]     wb_src,
    output logic [2:0]                 occ_cnt
);

    // Source indices travel on the 3-bit wb_src field.
    localparam int IDX_W  = 3;
    localparam int PSEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Hold buffers
    logic [NUM_SRC-1:0]   buf_v;
    logic [TAG_W-1:0]     buf_tag [NUM_SRC];
    logic [PAY_W-1:0]     buf_pay [NUM_SRC];

    // Unpacked source inputs
    logic [TAG_W-1:0]     in_tag  [NUM_SRC];
    logic [PAY_W-1:0]     in_pay  [NUM_SRC];

    // Round-robin arbitration
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     rr_nxt;
    logic [IDX_W-1:0]     last_idx;
    logic [NUM_SRC-1:0]   grant;
    logic [NUM_PORTS-1:0] port_vld;
    logic [IDX_W-1:0]     port_sel [NUM_PORTS];
    int                   scan_idx;
    int                   scan_cnt;
    logic [IDX_W-1:0]     scan_sel;

    // Next-state of the buffers
    logic [NUM_SRC-1:0]   accept;
    logic [NUM_SRC-1:0]   buf_v_nxt;
    logic [2:0]           occ_nxt;

    // Registered write ports
    logic [TAG_W-1:0]     wb_tag_r [NUM_PORTS];
    logic [PAY_W-1:0]     wb_pay_r [NUM_PORTS];
    logic [IDX_W-1:0]     wb_src_r [NUM_PORTS];

    genvar gi;

    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign in_tag[gi] = src_tag[gi*TAG_W +: TAG_W];
            assign in_pay[gi] = src_pay[gi*PAY_W +: PAY_W];
        end
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_pack
            assign wb_tag[gi*TAG_W +: TAG_W] = wb_tag_r[gi];
            assign wb_pay[gi*PAY_W +: PAY_W] = wb_pay_r[gi];
            assign wb_src[gi*3 +: 3]         = wb_src_r[gi];
        end
    endgenerate

    // Scan the occupied buffers from rr_ptr and hand the first NUM_PORTS of
    // them to ports 0..NUM_PORTS-1 in scan order.
    always_comb begin
        grant    = '0;
        port_vld = '0;
        last_idx = rr_ptr;
        scan_cnt = 0;
        scan_idx = 0;
        scan_sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_sel[p] = '0;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_SRC) begin
                scan_idx = scan_idx - NUM_SRC;
            end
            scan_sel = IDX_W'(scan_idx);
            if (buf_v[scan_sel] && (scan_cnt < NUM_PORTS)) begin
                grant[scan_sel]                   = 1'b1;
                port_vld[scan_cnt[PSEL_W-1:0]]    = 1'b1;
                port_sel[scan_cnt[PSEL_W-1:0]]    = scan_sel;
                last_idx                          = scan_sel;
                scan_cnt                          = scan_cnt + 1;
            end
        end
    end

    // Pointer moves just past the last source granted this cycle.
    always_comb begin
        if (last_idx == IDX_W'(NUM_SRC - 1)) begin
            rr_nxt = '0;
        end else begin
            rr_nxt = last_idx + 1'b1;
        end
    end

    // A buffer can take a new result when it is empty or being drained now;
    // flush blocks all acceptance for its cycle.
    assign src_ready = {NUM_SRC{~flush}} & (~buf_v | grant);

    // Transfer happens on ready plus a valid tag.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            accept[i] = src_ready[i] && (in_tag[i] != TAG_INVALID);
        end
    end

    // Refill wins over drain on the same buffer; flush wins over both.
    always_comb begin
        buf_v_nxt = buf_v;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (accept[i]) begin
                buf_v_nxt[i] = 1'b1;
            end else if (grant[i]) begin
                buf_v_nxt[i] = 1'b0;
            end
        end
        if (flush) begin
            buf_v_nxt = '0;
        end
        occ_nxt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            occ_nxt = occ_nxt + {2'b00, buf_v_nxt[i]};
        end
    end

    // Buffer occupancy, occupancy count and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_v   <= '0;
            occ_cnt <= '0;
            rr_ptr  <= '0;
        end else begin
            buf_v   <= buf_v_nxt;
            occ_cnt <= occ_nxt;
            if (flush) begin
                rr_ptr <= '0;
            end else if (|grant) begin
                rr_ptr <= rr_nxt;
            end
        end
    end

    // Buffer contents capture the source result on each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                buf_tag[i] <= '0;
                buf_pay[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (accept[i]) begin
                    buf_tag[i] <= in_tag[i];
                    buf_pay[i] <= in_pay[i];
                end
            end
        end
    end

    // Write ports load the granted buffer or go idle; payload and source
    // index are left alone when the port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wb_tag_r[p] <= TAG_INVALID;
                wb_pay_r[p] <= '0;
                wb_src_r[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (flush || !port_vld[p]) begin
                    wb_tag_r[p] <= TAG_INVALID;
                end else begin
                    wb_tag_r[p] <= buf_tag[port_sel[p]];
                    wb_pay_r[p] <= buf_pay[port_sel[p]];
                    wb_src_r[p] <= port_sel[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a saturated
// back-pressure run, each scenario pushing expected port contents into a
// queue and popping them as the write ports produce results.
module tb_wb_arbiter;

  localparam int NS = 5;
  localparam int NP = 2;
  localparam int TW = 6;
  localparam int PW = 65;
  localparam logic [TW-1:0] TAG_INV = 6'd0;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [NS*TW-1:0]  src_tag;
  logic [NS*PW-1:0]  src_pay;
  logic [NS-1:0]     src_ready;
  logic [NP*TW-1:0]  wb_tag;
  logic [NP*PW-1:0]  wb_pay;
  logic [NP*3-1:0]   wb_src;
  logic [2:0]        occ_cnt;

  // Entry layout: {source[2:0], tag[5:0]}; tag 0 means idle port.
  logic [8:0] exp_q[$];
  int n_cmp;
  int n_bad;

  wb_arbiter #(
    .NUM_SRC(NS), .NUM_PORTS(NP), .TAG_W(TW), .PAY_W(PW), .TAG_INVALID(TAG_INV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .src_tag(src_tag), .src_pay(src_pay), .src_ready(src_ready),
    .wb_tag(wb_tag), .wb_pay(wb_pay), .wb_src(wb_src), .occ_cnt(occ_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pay_of(input logic [TW-1:0] t);
    return {t, 53'h0, t};
  endfunction

  function automatic logic [8:0] ent(input int s, input int t);
    return {3'(s), 6'(t)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_src(input int s, input logic [TW-1:0] t);
    src_tag[s*TW +: TW] = t;
    src_pay[s*PW +: PW] = pay_of(t);
  endtask

  task automatic idle_all();
    for (int s = 0; s < NS; s++) drive_src(s, TAG_INV);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    idle_all();
    #3;
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (wb_tag[p*TW +: TW] !== TAG_INV) begin
        n_bad++; $display("FAIL reset_tag p%0d: got %0d want %0d", p, wb_tag[p*TW +: TW], TAG_INV);
      end
      n_cmp++;
      if (wb_pay[p*PW +: PW] !== '0) begin
        n_bad++; $display("FAIL reset_pay p%0d: got %h want 0", p, wb_pay[p*PW +: PW]);
      end
      n_cmp++;
      if (wb_src[p*3 +: 3] !== 3'd0) begin
        n_bad++; $display("FAIL reset_src p%0d: got %0d want 0", p, wb_src[p*3 +: 3]);
      end
    end
    n_cmp++;
    if (occ_cnt !== 3'd0) begin
      n_bad++; $display("FAIL reset_occ: got %0d want 0", occ_cnt);
    end
    n_cmp++;
    if (src_ready !== 5'b11111) begin
      n_bad++; $display("FAIL reset_ready: got %b want 11111", src_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill_all();
    int drv [4][5] = '{'{1, 2, 3, 4, 5}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}};
    logic [8:0] e;
    do_reset();
    exp_q.delete();
    exp_q.push_back(ent(0, 0)); exp_q.push_back(ent(0, 0));
    exp_q.push_back(ent(0, 1)); exp_q.push_back(ent(1, 2));
    exp_q.push_back(ent(2, 3)); exp_q.push_back(ent(3, 4));
    exp_q.push_back(ent(4, 5)); exp_q.push_back(ent(0, 0));
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < NS; s++) drive_src(s, 6'(drv[c][s]));
      #1;
      for (int s = 0; s < NS; s++) begin
        if (drv[c][s] != 0) begin
          n_cmp++;
          if (src_ready[s] !== 1'b1) begin
            n_bad++; $display("FAIL fill_ready c%0d s%0d: got %b want 1", c, s, src_ready[s]);
          end
        end
      end
      if (c == 1) begin
        n_cmp++;
        if (src_ready !== 5'b00011) begin
          n_bad++; $display("FAIL fill_ready_grant: got %b want 00011", src_ready);
        end
      end
      step();
      for (int p = 0; p < NP; p++) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (wb_tag[p*TW +: TW] !== e[5:0]) begin
          n_bad++; $display("FAIL fill_tag c%0d p%0d: got %0d want %0d", c, p, wb_tag[p*TW +: TW], e[5:0]);
        end
        if (e[5:0] != TAG_INV) begin
          n_cmp++;
          if (wb_src[p*3 +: 3] !== e[8:6]) begin
            n_bad++; $display("FAIL fill_src c%0d p%0d: got %0d want %0d", c, p, wb_src[p*3 +: 3], e[8:6]);
          end
          n_cmp++;
          if (wb_pay[p*PW +: PW] !== pay_of(e[5:0])) begin
            n_bad++; $display("FAIL fill_pay c%0d p%0d: got %h want %h", c, p, wb_pay[p*PW +: PW], pay_of(e[5:0]));
          end
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int drv [8][5] = '{'{11, 12, 13, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0},
                       '{14, 15, 0, 0, 16}, '{17, 0, 0, 18, 0}, '{0, 0, 0, 0, 0},
                       '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}};
    logic [8:0] e;
    do_reset();
    exp_q.delete();
    exp_q.push_back(ent(0, 0));  exp_q.push_back(ent(0, 0));
    exp_q.push_back(ent(0, 11)); exp_q.push_back(ent(1, 12));
    exp_q.push_back(ent(2, 13)); exp_q.push_back(ent(0, 0));
    exp_q.push_back(ent(0, 0));  exp_q.push_back(ent(0, 0));
    exp_q.push_back(ent(4, 16)); exp_q.push_back(ent(0, 14));
    exp_q.push_back(ent(1, 15)); exp_q.push_back(ent(3, 18));
    exp_q.push_back(ent(0, 17)); exp_q.push_back(ent(0, 0));
    exp_q.push_back(ent(0, 0));  exp_q.push_back(ent(0, 0));
    for (int c = 0; c < 8; c++) begin
      for (int s = 0; s < NS; s++) drive_src(s, 6'(drv[c][s]));
      #1;
      for (int s = 0; s < NS; s++) begin
        if (drv[c][s] != 0) begin
          n_cmp++;
          if (src_ready[s] !== 1'b1) begin
            n_bad++; $display("FAIL rr_ready c%0d s%0d: got %b want 1", c, s, src_ready[s]);
          end
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (src_ready !== 5'b11101) begin
          n_bad++; $display("FAIL rr_ready_vec: got %b want 11101", src_ready);
        end
      end
      step();
      for (int p = 0; p < NP; p++) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (wb_tag[p*TW +: TW] !== e[5:0]) begin
          n_bad++; $display("FAIL rr_tag c%0d p%0d: got %0d want %0d", c, p, wb_tag[p*TW +: TW], e[5:0]);
        end
        if (e[5:0] != TAG_INV) begin
          n_cmp++;
          if (wb_src[p*3 +: 3] !== e[8:6]) begin
            n_bad++; $display("FAIL rr_src c%0d p%0d: got %0d want %0d", c, p, wb_src[p*3 +: 3], e[8:6]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] cur [NS];
    bit            acc [NS];
    logic [TW-1:0] nxt;
    int            since2;
    bit            seen2;
    bit            found;
    do_reset();
    exp_q.delete();
    nxt = 6'd20;
    for (int s = 0; s < NS; s++) begin
      cur[s] = nxt;
      nxt = nxt + 6'd1;
    end
    since2 = 0;
    for (int c = 0; c < 18; c++) begin
      for (int s = 0; s < NS; s++) drive_src(s, (c < 15) ? cur[s] : TAG_INV);
      #1;
      for (int s = 0; s < NS; s++) begin
        acc[s] = 1'b0;
        if (c < 15 && src_ready[s] === 1'b1) begin
          exp_q.push_back({3'(s), cur[s]});
          acc[s] = 1'b1;
        end
      end
      step();
      for (int s = 0; s < NS; s++) begin
        if (acc[s]) begin
          cur[s] = nxt;
          nxt = nxt + 6'd1;
        end
      end
      seen2 = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (wb_tag[p*TW +: TW] !== TAG_INV) begin
          found = 1'b0;
          n_cmp++;
          for (int k = 0; k < exp_q.size(); k++) begin
            if (!found && exp_q[k][8:6] == wb_src[p*3 +: 3]) begin
              found = 1'b1;
              if (exp_q[k][5:0] !== wb_tag[p*TW +: TW]) begin
                n_bad++; $display("FAIL b2b_order c%0d p%0d src%0d: got %0d want %0d",
                                  c, p, wb_src[p*3 +: 3], wb_tag[p*TW +: TW], exp_q[k][5:0]);
              end
              exp_q.delete(k);
            end
          end
          if (!found) begin
            n_bad++; $display("FAIL b2b_unexpected c%0d p%0d: got tag %0d src %0d want none",
                              c, p, wb_tag[p*TW +: TW], wb_src[p*3 +: 3]);
          end
          if (wb_src[p*3 +: 3] === 3'd2) seen2 = 1'b1;
        end
      end
      since2 = seen2 ? 0 : since2 + 1;
      if (c < 15) begin
        n_cmp++;
        if (since2 > 2) begin
          n_bad++; $display("FAIL b2b_fair c%0d: got %0d idle cycles for src2 want <=2", c, since2);
        end
        n_cmp++;
        if (occ_cnt !== 3'd5) begin
          n_bad++; $display("FAIL b2b_occ c%0d: got %0d want 5", c, occ_cnt);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL b2b_lost: got %0d tags never written want 0", exp_q.size());
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int s = 0; s < 4; s++) drive_src(s, 6'(31 + s));
    step();
    idle_all();
    n_cmp++;
    if (occ_cnt !== 3'd4) begin
      n_bad++; $display("FAIL flush_occ_pre: got %0d want 4", occ_cnt);
    end
    flush = 1'b1;
    drive_src(4, 6'd35);
    #1;
    n_cmp++;
    if (src_ready !== 5'b00000) begin
      n_bad++; $display("FAIL flush_ready: got %b want 00000", src_ready);
    end
    step();
    flush = 1'b0;
    drive_src(4, TAG_INV);
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < NP; p++) begin
        n_cmp++;
        if (wb_tag[p*TW +: TW] !== TAG_INV) begin
          n_bad++; $display("FAIL flush_tag c%0d p%0d: got %0d want %0d", c, p, wb_tag[p*TW +: TW], TAG_INV);
        end
      end
      n_cmp++;
      if (occ_cnt !== 3'd0) begin
        n_bad++; $display("FAIL flush_occ c%0d: got %0d want 0", c, occ_cnt);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    logic [8:0] e;
    do_reset();
    exp_q.delete();
    for (int s = 0; s < NS; s++) drive_src(s, 6'(21 + s));
    step();
    idle_all();
    step();
    exp_q.push_back(ent(0, 21)); exp_q.push_back(ent(1, 22));
    for (int p = 0; p < NP; p++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (wb_tag[p*TW +: TW] !== e[5:0]) begin
        n_bad++; $display("FAIL areset_pre p%0d: got %0d want %0d", p, wb_tag[p*TW +: TW], e[5:0]);
      end
    end
    n_cmp++;
    if (occ_cnt !== 3'd3) begin
      n_bad++; $display("FAIL areset_occ_pre: got %0d want 3", occ_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (wb_tag[p*TW +: TW] !== TAG_INV) begin
        n_bad++; $display("FAIL areset_tag p%0d: got %0d want %0d", p, wb_tag[p*TW +: TW], TAG_INV);
      end
    end
    n_cmp++;
    if (occ_cnt !== 3'd0) begin
      n_bad++; $display("FAIL areset_occ: got %0d want 0", occ_cnt);
    end
    #2;
    rst_n = 1'b1;
    drive_src(4, 6'd7);
    #1;
    n_cmp++;
    if (src_ready !== 5'b11111) begin
      n_bad++; $display("FAIL areset_ready: got %b want 11111", src_ready);
    end
    exp_q.push_back(ent(0, 0)); exp_q.push_back(ent(0, 0));
    exp_q.push_back(ent(4, 7)); exp_q.push_back(ent(0, 0));
    exp_q.push_back(ent(0, 0)); exp_q.push_back(ent(0, 0));
    for (int c = 0; c < 3; c++) begin
      step();
      idle_all();
      for (int p = 0; p < NP; p++) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (wb_tag[p*TW +: TW] !== e[5:0]) begin
          n_bad++; $display("FAIL areset_post c%0d p%0d: got %0d want %0d", c, p, wb_tag[p*TW +: TW], e[5:0]);
        end
        if (e[5:0] != TAG_INV) begin
          n_cmp++;
          if (wb_src[p*3 +: 3] !== e[8:6]) begin
            n_bad++; $display("FAIL areset_src c%0d p%0d: got %0d want %0d", c, p, wb_src[p*3 +: 3], e[8:6]);
          end
        end
      end
    end
  endtask

  task automatic test_grant_refill();
    int drv [4][5] = '{'{0, 9, 0, 0, 0}, '{0, 10, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}};
    logic [8:0] e;
    do_reset();
    exp_q.delete();
    exp_q.push_back(ent(0, 0));  exp_q.push_back(ent(0, 0));
    exp_q.push_back(ent(1, 9));  exp_q.push_back(ent(0, 0));
    exp_q.push_back(ent(1, 10)); exp_q.push_back(ent(0, 0));
    exp_q.push_back(ent(0, 0));  exp_q.push_back(ent(0, 0));
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < NS; s++) drive_src(s, 6'(drv[c][s]));
      #1;
      for (int s = 0; s < NS; s++) begin
        if (drv[c][s] != 0) begin
          n_cmp++;
          if (src_ready[s] !== 1'b1) begin
            n_bad++; $display("FAIL refill_ready c%0d s%0d: got %b want 1", c, s, src_ready[s]);
          end
        end
      end
      step();
      for (int p = 0; p < NP; p++) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (wb_tag[p*TW +: TW] !== e[5:0]) begin
          n_bad++; $display("FAIL refill_tag c%0d p%0d: got %0d want %0d", c, p, wb_tag[p*TW +: TW], e[5:0]);
        end
        if (e[5:0] != TAG_INV) begin
          n_cmp++;
          if (wb_pay[p*PW +: PW] !== pay_of(e[5:0])) begin
            n_bad++; $display("FAIL refill_pay c%0d p%0d: got %h want %h", c, p, wb_pay[p*PW +: PW], pay_of(e[5:0]));
          end
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    src_tag = '0;
    src_pay = '0;
    test_reset();
    test_fill_all();
    test_round_robin();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_grant_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
